// File: rtl/multicycle_proc.sv
// Multi-cycle register-file processor: MV/MVI, ALU ops (ADD/SUB/AND/OR/XOR) and MVNZ over one shared bus.
// Optional feature macro STATUS_FLAGS_EN adds zero_flag/carry_flag outputs updated on ALU ops.
module multicycle_proc #(
   parameter int REG_WIDTH = 16,
   parameter int NUM_REGS  = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 run,
   input  logic [REG_WIDTH-1:0] din,
   output logic [REG_WIDTH-1:0] bus,
   output logic                 done,
   output logic [1:0]           t_step
`ifdef STATUS_FLAGS_EN
   ,
   output logic                 zero_flag,
   output logic                 carry_flag
`endif
);

   localparam int ADDR_W  = $clog2(NUM_REGS);
   localparam int INSTR_W = 3 + 2 * ADDR_W;

   typedef enum logic [1:0] {T0, T1, T2, T3} step_e;
   typedef enum logic [2:0] {
      OP_MV, OP_MVI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MVNZ
   } op_e;

   step_e                step, next_step;
   logic [INSTR_W-1:0]   ir;
   logic [REG_WIDTH-1:0] a, g;
   logic [REG_WIDTH-1:0] regs [NUM_REGS];

   op_e                  op;
   logic [ADDR_W-1:0]    rx, ry;
   logic                 ir_load, a_load, g_load, reg_we;
   logic [REG_WIDTH-1:0] alu_result;

   assign op     = op_e'(ir[INSTR_W-1 -: 3]);
   assign rx     = ir[2*ADDR_W-1 -: ADDR_W];
   assign ry     = ir[ADDR_W-1:0];
   assign t_step = step;

   // NOTE: every output of a combinational block gets a default first so no path infers a latch.
   always_comb begin
      next_step = step;
      bus       = '0;
      done      = 1'b0;
      ir_load   = 1'b0;
      a_load    = 1'b0;
      g_load    = 1'b0;
      reg_we    = 1'b0;
      case (step)
         T0: begin
            if (run) begin
               ir_load   = 1'b1;
               next_step = T1;
            end
         end
         T1: begin
            case (op)
               OP_MV: begin
                  bus       = regs[ry];
                  reg_we    = 1'b1;
                  done      = 1'b1;
                  next_step = T0;
               end
               OP_MVI: begin
                  bus       = din;
                  reg_we    = 1'b1;
                  done      = 1'b1;
                  next_step = T0;
               end
               OP_MVNZ: begin
                  // G is left over from the last ALU op; a zero G suppresses the move.
                  if (g != '0) begin
                     bus    = regs[ry];
                     reg_we = 1'b1;
                  end
                  done      = 1'b1;
                  next_step = T0;
               end
               default: begin
                  bus       = regs[rx];
                  a_load    = 1'b1;
                  next_step = T2;
               end
            endcase
         end
         T2: begin
            bus       = regs[ry];
            g_load    = 1'b1;
            next_step = T3;
         end
         default: begin
            bus       = g;
            reg_we    = 1'b1;
            done      = 1'b1;
            next_step = T0;
         end
      endcase
   end

   always_comb begin
      alu_result = '0;
      case (op)
         OP_ADD:  alu_result = a + regs[ry];
         OP_SUB:  alu_result = a - regs[ry];
         OP_AND:  alu_result = a & regs[ry];
         OP_OR:   alu_result = a | regs[ry];
         OP_XOR:  alu_result = a ^ regs[ry];
         default: alu_result = '0;
      endcase
   end

   // NOTE: sequential state is written only with non-blocking assignments.
   always_ff @(posedge clk) begin
      if (rst) begin
         step <= T0;
         ir   <= '0;
         a    <= '0;
         g    <= '0;
         // NOTE: the register file is reset explicitly because software may read Rn before writing it.
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else begin
         step <= next_step;
         if (ir_load) ir <= din[INSTR_W-1:0];
         if (a_load)  a  <= bus;
         if (g_load)  g  <= alu_result;
         if (reg_we)  regs[rx] <= bus;
      end
   end

`ifdef STATUS_FLAGS_EN
   logic alu_carry;

   // Unsigned wrap detection: a sum that wrapped is smaller than its first operand.
   always_comb begin
      alu_carry = 1'b0;
      if (op == OP_ADD) begin
         alu_carry = alu_result < a;
      end else if (op == OP_SUB) begin
         alu_carry = a < regs[ry];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         zero_flag  <= 1'b0;
         carry_flag <= 1'b0;
      end else if (g_load) begin
         zero_flag  <= (alu_result == '0);
         carry_flag <= alu_carry;
      end
   end
`endif

endmodule
